serial_comparator: RTL

Sequential WIDTH-bit unsigned magnitude comparator. It captures two operands on a start handshake and resolves them MSB-first, one bit per clock, using the same per-bit greater/less relation as the team's 1-bit COMPARATOR cell. It reports the result on the K (A greater than B) and L (A less than B) flags with a one-cycle done pulse. It is the multi-bit serial front end that drives the 1-bit comparison repeatedly, and it sits between an operand producer and result-consuming control logic.

---
 rtl/serial_comparator.sv | 98 +++++++++
 1 files changed

// File: rtl/serial_comparator.sv
// MSB-first serial unsigned magnitude comparator: K = A > B, L = A < B, one bit per clock.
// Define SERIAL_COMPARATOR_EARLY_EXIT_EN to finish on the first differing bit.
module serial_comparator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             busy,
    output logic             done,
    output logic             K,
    output logic             L
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             k_q, k_d;
    logic             l_q, l_d;
    logic             bit_a, bit_b, first_diff;

    always_comb begin
        state_d    = state_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        l_d        = l_q;
        bit_a      = sa_q[WIDTH-1];
        bit_b      = sb_q[WIDTH-1];
        // Flags freeze once any difference has been recorded.
        first_diff = !k_q && !l_q && (bit_a != bit_b);

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    sa_d    = A_in;
                    sb_d    = B_in;
                    cnt_d   = CntW'(WIDTH);
                    k_d     = 1'b0;
                    l_d     = 1'b0;
                    state_d = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                if (first_diff) begin
                    k_d = bit_a & ~bit_b;
                    l_d = ~bit_a & bit_b;
                end
                sa_d  = {sa_q[WIDTH-2:0], 1'b0};
                sb_d  = {sb_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                end
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
                if (first_diff) begin
                    state_d = StDone;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            k_q     <= 1'b0;
            l_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            l_q     <= l_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign K    = k_q;
    assign L    = l_q;

endmodule
